sr_bank_arbiter: RTL and testbench
==================================

// Module: sr_bank_arbiter
// PURPOSE
//  Shares one bank of NBITS set/reset flag bits among NREQ requesters. Each
//  requester asks for the bank and presents per-bit set/clear masks. A
//  round-robin arbiter grants one requester per transaction. The granted
//  masks are applied to the bank as synchronous SR flip-flop updates. Sits
//  between the status/control agents and the shared SR flag register.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  NBITS  8  width of the shared SR flag bank
// PORTS
//  clk       in   1           rising-edge clock
//  rst_n     in   1           asynchronous, active-low reset
//  req       in   NREQ        per-requester request; held high until its gnt pulse
//  set_mask  in   NREQ*NBITS  requester i uses bits [i*NBITS +: NBITS]; 1 = set bit
//  clr_mask  in   NREQ*NBITS  same slicing as set_mask; 1 = clear bit
//  gnt       out  NREQ        one-hot, one-cycle pulse: requester's masks applied
//  busy      out  1           high whenever FSM is not in IDLE
//  q         out  NBITS       flag bank state
//  qbar      out  NBITS       ~q, combinational
//  conflict  out  1           sticky: some transaction had set&clr on the same bit
//  clr_conf  in   1           synchronous clear of conflict (clears before same-cycle set)
// BEHAVIOUR
//  Reset (rst_n=0, async): q=0, qbar=all 1s, gnt=0, busy=0, conflict=0,
//    state=IDLE, rr_ptr=0.
//  FSM states: IDLE -> ARB -> APPLY -> IDLE.
//   IDLE: if |req, go to ARB next cycle; otherwise stay.
//   ARB: pick the first requester with req=1, searching from rr_ptr upward
//     with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...). Latch sel.
//     If req dropped to 0 (protocol violation), return to IDLE with no grant.
//   APPLY: per bit b, using masks of sel:
//     S=0,R=0 hold; S=0,R=1 q=0; S=1,R=0 q=1;
//     S=1,R=1 conflict case (see CONFIGURATION), and set conflict=1.
//     In the same cycle: gnt[sel]=1 for exactly this cycle,
//     rr_ptr = (sel+1) mod NREQ, then return to IDLE.
//  Latency: req rise to gnt pulse = 3 clocks; q updated on the gnt edge.
//  Throughput: one grant per 3 cycles. A requester wanting back-to-back
//    service keeps req high after gnt.
//  Fairness: a requester holding req is granted within NREQ transactions.
//  Masks are sampled only in APPLY. Requester must hold them stable from
//    req rise to gnt.
//  Reset asserted mid-transaction: abort immediately. No gnt is issued.
//    q returns to 0.
//  x never appears on q. The S=R=1 case is always resolved deterministically.
// CONFIGURATION
//  SR_CONFLICT_TOGGLE_EN defined: S=R=1 toggles the bit (JK semantics),
//    q[b] <= ~q[b].
//  Not defined: S=R=1 resolves clear-wins, q[b] <= 0.
//  The conflict flag is set in both builds.
// TESTING
//  1. Reset: rst_n=0 mid-APPLY -> q=00, gnt=0, busy=0 at once; IDLE after release.
//  2. Single request: req=0001, set=0x0F, clr=0 -> gnt=0001 3 clocks later, q=0x0F.
//  3. Round-robin: req=1111 held for 4 grants -> gnt order 0001,0010,0100,1000,
//     then 0001 again.
//  4. Set/clear: q=0xFF; req1 with clr=0xF0 -> q=0x0F; qbar=0xF0.
//  5. Conflict: q=0x01; set=0x03, clr=0x03 -> q=0x00 (default) or 0x02
//     (SR_CONFLICT_TOGGLE_EN); conflict=1 until clr_conf.
//  6. Withdraw: req pulses for 1 cycle then drops -> ARB back to IDLE,
//     no gnt, q unchanged.

Source files
------------

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one bank of NBITS SR flag bits.
// Optional macro SR_CONFLICT_TOGGLE_EN: S=R=1 toggles the bit (JK); otherwise clear wins.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] set_mask,
  input  logic [NREQ*NBITS-1:0] clr_mask,
  input  logic                  clr_conf,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NBITS-1:0]      q,
  output logic [NBITS-1:0]      qbar,
  output logic                  conflict
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ARB, APPLY} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     sel_reg;
  logic [PW-1:0]     rr_ptr_reg;
  logic [NBITS-1:0]  q_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              conflict_reg;

  logic [NBITS-1:0]  set_arr [NREQ];
  logic [NBITS-1:0]  clr_arr [NREQ];
  logic [NBITS-1:0]  sel_set, sel_clr;
  logic [NBITS-1:0]  q_next;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     rr_ptr_next;
  logic              conflict_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign set_arr[gi] = set_mask[gi*NBITS +: NBITS];
      assign clr_arr[gi] = clr_mask[gi*NBITS +: NBITS];
    end
  endgenerate

  assign sel_set = set_arr[sel_reg];
  assign sel_clr = clr_arr[sel_reg];

  // Per-bit SR update; the S=R=1 resolution is the only build-dependent piece.
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_bit
      logic both_val;
`ifdef SR_CONFLICT_TOGGLE_EN
      assign both_val = ~q_reg[gi];
`else
      assign both_val = 1'b0;
`endif
      assign q_next[gi] = (sel_set[gi] && sel_clr[gi]) ? both_val :
                          sel_set[gi]                  ? 1'b1     :
                          sel_clr[gi]                  ? 1'b0     :
                                                         q_reg[gi];
    end
  endgenerate

  // Search from rr_ptr upward with wrap-around; first active request wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!pick_found && req[PW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign rr_ptr_next = (sel_reg == PW'(NREQ - 1)) ? '0 : sel_reg + PW'(1);

  // clr_conf is applied first so a conflict in the same cycle still sticks.
  assign conflict_next = (conflict_reg & ~clr_conf) |
                         ((state_reg == APPLY) && |(sel_set & sel_clr));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = ARB;
      ARB:     state_next = pick_found ? APPLY : IDLE;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      rr_ptr_reg   <= '0;
      q_reg        <= '0;
      gnt_reg      <= '0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= '0;
      conflict_reg <= conflict_next;
      if (state_reg == ARB && pick_found)
        sel_reg <= pick_idx;
      if (state_reg == APPLY) begin
        q_reg      <= q_next;
        gnt_reg    <= NREQ'(1) << sel_reg;
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  assign gnt      = gnt_reg;
  assign busy     = (state_reg != IDLE);
  assign q        = q_reg;
  assign qbar     = ~q_reg;
  assign conflict = conflict_reg;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed self-checking bench for sr_bank_arbiter (NREQ=4, NBITS=8).
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] set_mask;
  logic [NREQ*NBITS-1:0] clr_mask;
  logic                  clr_conf;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NBITS-1:0]      q;
  logic [NBITS-1:0]      qbar;
  logic                  conflict;

  int checks   = 0;
  int failures = 0;

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .clr_conf (clr_conf),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .qbar     (qbar),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_masks(input int i, input logic [7:0] s, input logic [7:0] c);
    set_mask = '0;
    clr_mask = '0;
    set_mask[i*NBITS +: NBITS] = s;
    clr_mask[i*NBITS +: NBITS] = c;
  endtask

  // One full transaction by requester i alone; optional clr_conf on the APPLY edge.
  task automatic txn(input string tag, input int i, input logic [7:0] s, input logic [7:0] c,
                     input logic clr_at_apply, input logic [7:0] exp_q);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << i;
    load_masks(i, s, c);
    req = exp_g;
    tick();
    check({tag, "_busy_arb"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_gnt_early"}, 32'(gnt), 32'd0);
    if (clr_at_apply) clr_conf = 1'b1;
    tick();
    clr_conf = 1'b0;
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    $display("txn %s: req=%b gnt=%b q=%h conflict=%b", tag, exp_g, gnt, q, conflict);
    req = '0;
    tick();
    check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    logic [7:0] exp_conf_q;
    logic [7:0] exp_conf2_q;
    logic [7:0] exp_pre_rst_q;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
`ifdef SR_CONFLICT_TOGGLE_EN
    exp_conf_q    = 8'h02;
    exp_conf2_q   = 8'h06;
    exp_pre_rst_q = 8'h5B;
`else
    exp_conf_q    = 8'h00;
    exp_conf2_q   = 8'h00;
    exp_pre_rst_q = 8'h5A;
`endif

    rst_n = 1'b0; req = '0; set_mask = '0; clr_mask = '0; clr_conf = 1'b0;
    tick();
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_qbar", 32'(qbar), 32'hFF);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Single request: three clocks from req to gnt.
    txn("single", 0, 8'h0F, 8'h00, 1'b0, 8'h0F);
    check("single_busy_after", 32'(busy), 32'd0);

    // Round-robin from a fresh pointer.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    load_masks(0, 8'h00, 8'h00);
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick();
      tick();
      check("rr_gap", 32'(gnt), 32'd0);
      tick();
      check("rr_gnt", 32'(gnt), 32'(rr_exp[g]));
      $display("rr grant %0d: gnt=%b", g, gnt);
    end
    req = '0;
    tick();
    check("rr_end_gnt", 32'(gnt), 32'd0);
    check("rr_end_busy", 32'(busy), 32'd0);

    // Set then clear.
    txn("setall", 0, 8'hFF, 8'h00, 1'b0, 8'hFF);
    txn("clrhi", 1, 8'h00, 8'hF0, 1'b0, 8'h0F);
    check("clrhi_qbar", 32'(qbar), 32'hF0);

    // Conflict handling and sticky flag.
    txn("prep01", 2, 8'h01, 8'hFE, 1'b0, 8'h01);
    check("prep01_conflict", 32'(conflict), 32'd0);
    txn("conf", 3, 8'h03, 8'h03, 1'b0, exp_conf_q);
    check("conf_flag", 32'(conflict), 32'd1);
    txn("conf_hold", 0, 8'h00, 8'h00, 1'b0, exp_conf_q);
    check("conf_sticky", 32'(conflict), 32'd1);
    clr_conf = 1'b1;
    tick();
    clr_conf = 1'b0;
    check("conf_cleared", 32'(conflict), 32'd0);
    txn("conf_same_cycle", 1, 8'h04, 8'h04, 1'b1, exp_conf2_q);
    check("conf_set_beats_clr", 32'(conflict), 32'd1);
    clr_conf = 1'b1;
    tick();
    clr_conf = 1'b0;
    check("conf_cleared2", 32'(conflict), 32'd0);

    // Withdrawn request: ARB returns to IDLE without a grant.
    txn("pre_wd", 0, 8'h5A, 8'hA5, 1'b0, 8'h5A);
    load_masks(2, 8'hFF, 8'h00);
    req = 4'b0100;
    tick();
    req = '0;
    check("wd_busy_arb", 32'(busy), 32'd1);
    tick();
    check("wd_busy_idle", 32'(busy), 32'd0);
    check("wd_gnt0", 32'(gnt), 32'd0);
    tick();
    check("wd_gnt1", 32'(gnt), 32'd0);
    check("wd_q", 32'(q), 32'h5A);
    $display("withdraw: gnt=%b q=%h busy=%b", gnt, q, busy);

    // Reset in the middle of APPLY aborts at once.
    txn("pre_rst", 3, 8'h01, 8'h01, 1'b0, exp_pre_rst_q);
    check("pre_rst_conflict", 32'(conflict), 32'd1);
    load_masks(1, 8'hFF, 8'h00);
    req = 4'b0010;
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", 32'(q), 32'h00);
    check("mid_rst_qbar", 32'(qbar), 32'hFF);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_conflict", 32'(conflict), 32'd0);
    req = '0;
    tick();
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'd0);
    check("post_rst_q", 32'(q), 32'h00);

    // Pointer restarted at 0: requester 1 beats requester 3.
    set_mask = '0;
    clr_mask = '0;
    req = 4'b1010;
    tick();
    tick();
    tick();
    check("post_rst_rr", 32'(gnt), 32'b0010);
    $display("post reset grant: gnt=%b", gnt);
    req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
